rom_for_led_peripheral: RTL and testbench

Self-contained write sequencer for the LED subsystem. After reset it replays a fixed ROM program of (address, data) register writes, one per cycle, into an internal memory-mapped LED peripheral that drives a 16-bit LED image. It then idles with writes disabled. It serves as a boot-time LED pattern loader and as a smoke test of the LED peripheral's bus.

---
 rtl/led_pkg.sv | 26 ++
 rtl/led_peripheral_regs.sv | 30 +++
 rtl/rom_for_led_peripheral.sv | 66 ++++++
 tb/tb_rom_for_led_peripheral.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED boot-pattern loader.
//   ADDR_LED_LO / ADDR_LED_HI : default register addresses of led[7:0] / led[15:8]
//   LED_W / BUS_W             : LED image width and bus byte width
//   rom_entry_t               : one ROM write, {addr, data}
//   ROM_DEFAULT               : the boot program replayed after every reset
package led_pkg;

   localparam logic [7:0] ADDR_LED_LO = 8'h00;
   localparam logic [7:0] ADDR_LED_HI = 8'h01;
   localparam int         LED_W       = 16;
   localparam int         BUS_W       = 8;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } rom_entry_t;

   // Index k is the k-th write issued after reset.
   localparam rom_entry_t [3:0] ROM_DEFAULT = '{
      3: '{addr: ADDR_LED_HI, data: 8'hF0},
      2: '{addr: ADDR_LED_LO, data: 8'h0F},
      1: '{addr: ADDR_LED_HI, data: 8'h55},
      0: '{addr: ADDR_LED_LO, data: 8'hAA}
   };

endpackage

// File: rtl/led_peripheral_regs.sv
// Memory-mapped LED peripheral: two byte registers forming a 16-bit LED image.
//   clk, rst     : clock, synchronous active-high reset
//   wr_en        : write strobe
//   data_address : register address; ADDR_LED_LO -> led[7:0], ADDR_LED_HI -> led[15:8]
//   write_data   : byte written on a strobed edge
//   led          : current LED image; writes to other addresses are ignored
module led_peripheral_regs #(
   parameter logic [7:0] ADDR_LED_LO = led_pkg::ADDR_LED_LO,
   parameter logic [7:0] ADDR_LED_HI = led_pkg::ADDR_LED_HI
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [7:0]  data_address,
   input  logic [7:0]  write_data,
   output logic [15:0] led
);

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         led <= '0;
      end else if (wr_en) begin
         if (data_address == ADDR_LED_LO) led[7:0]  <= write_data;
         if (data_address == ADDR_LED_HI) led[15:8] <= write_data;
      end
   end

endmodule

// File: rtl/rom_for_led_peripheral.sv
// Boot-time LED pattern loader: after reset, replays ROM writes one per cycle
// into an internal LED peripheral, then idles with the bus zeroed.
//   wr_en        : write strobe (high for DEPTH cycles after reset release)
//   data_address : address of the current write
//   write_data   : data of the current write
//   clk, rst     : clock, synchronous active-high reset
// Internal probes: wr_ptr (ROM index, saturates at DEPTH), led (LED image).
module rom_for_led_peripheral #(
   parameter int                             DEPTH       = 4,
   parameter logic [7:0]                     ADDR_LED_LO = led_pkg::ADDR_LED_LO,
   parameter logic [7:0]                     ADDR_LED_HI = led_pkg::ADDR_LED_HI,
   parameter led_pkg::rom_entry_t [DEPTH-1:0] ROM        = led_pkg::ROM_DEFAULT
) (
   output logic       wr_en,
   output logic [7:0] data_address,
   output logic [7:0] write_data,
   input  logic       clk,
   input  logic       rst
);

   import led_pkg::*;

   localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [2:0] DEPTH_P = 3'(DEPTH);

   logic [2:0]       wr_ptr;
   logic [LED_W-1:0] led;
   rom_entry_t       entry;

   // Only read while wr_ptr < DEPTH, so the truncated index is always in range.
   assign entry = ROM[wr_ptr[IDX_W-1:0]];

   // wr_ptr saturates at DEPTH: the program runs once per reset, never wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         wr_en        <= 1'b0;
         data_address <= '0;
         write_data   <= '0;
      end else if (wr_ptr < DEPTH_P) begin
         wr_ptr       <= wr_ptr + 3'd1;
         wr_en        <= 1'b1;
         data_address <= entry.addr;
         write_data   <= entry.data;
      end else begin
         wr_en        <= 1'b0;
         data_address <= '0;
         write_data   <= '0;
      end
   end

   // The peripheral samples the registered bus, so each LED update lands one
   // edge after its strobe appears on the outputs.
   led_peripheral_regs #(
      .ADDR_LED_LO (ADDR_LED_LO),
      .ADDR_LED_HI (ADDR_LED_HI)
   ) u_regs (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .data_address (data_address),
      .write_data   (write_data),
      .led          (led)
   );

endmodule

// File: tb/tb_rom_for_led_peripheral.sv
module tb_rom_for_led_peripheral;

   import led_pkg::*;

   localparam rom_entry_t [3:0] ROM_ALT = '{
      3: '{addr: 8'h01, data: 8'hF0},
      2: '{addr: 8'h00, data: 8'h0F},
      1: '{addr: 8'h07, data: 8'h55},
      0: '{addr: 8'h00, data: 8'hAA}
   };

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en, wr_en_b;
   logic [7:0] data_address, data_address_b;
   logic [7:0] write_data, write_data_b;

   int checks = 0;
   int errors = 0;
   int cnt    = 0;   // consecutive non-reset edges seen, for the model

   always #5 clk = ~clk;

   rom_for_led_peripheral dut (
      .wr_en        (wr_en),
      .data_address (data_address),
      .write_data   (write_data),
      .clk          (clk),
      .rst          (rst)
   );

   rom_for_led_peripheral #(.ROM(ROM_ALT)) dut_alt (
      .wr_en        (wr_en_b),
      .data_address (data_address_b),
      .write_data   (write_data_b),
      .clk          (clk),
      .rst          (rst)
   );

   typedef struct packed {
      logic        wr_en;
      logic [7:0]  addr;
      logic [7:0]  data;
      logic [2:0]  ptr;
      logic [15:0] led;
   } obs_t;

   typedef struct {
      logic rst;
      obs_t exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive rst away from the edge, then sample just after it.
   task automatic step(input logic r);
      @(negedge clk);
      rst = r;
      @(posedge clk);
      #1;
      if (r) cnt = 0;
      else if (cnt < 1000) cnt++;
   endtask

   // Reference: after n clean edges, n-1 is the entry on the bus (if any) and
   // the first min(n-1, 4) entries have landed in the LED image.
   function automatic obs_t model(input rom_entry_t [3:0] rom, input int n);
      obs_t o;
      int   landed;
      o = '0;
      o.ptr = 3'((n < 4) ? n : 4);
      if (n >= 1 && n <= 4) begin
         o.wr_en = 1'b1;
         o.addr  = rom[n-1].addr;
         o.data  = rom[n-1].data;
      end
      landed = (n - 1 < 4) ? n - 1 : 4;
      for (int i = 0; i < landed; i++) begin
         if (rom[i].addr == 8'h00) o.led[7:0]  = rom[i].data;
         if (rom[i].addr == 8'h01) o.led[15:8] = rom[i].data;
      end
      return o;
   endfunction

   task automatic check_main(input string tag, input obs_t e);
      check({tag, ".wr_en"}, 32'(wr_en), 32'(e.wr_en));
      check({tag, ".addr"},  32'(data_address), 32'(e.addr));
      check({tag, ".data"},  32'(write_data), 32'(e.data));
      check({tag, ".ptr"},   32'(dut.wr_ptr), 32'(e.ptr));
      check({tag, ".led"},   32'(dut.led), 32'(e.led));
   endtask

   task automatic check_alt(input string tag, input obs_t e);
      check({tag, ".alt_wr_en"}, 32'(wr_en_b), 32'(e.wr_en));
      check({tag, ".alt_addr"},  32'(data_address_b), 32'(e.addr));
      check({tag, ".alt_data"},  32'(write_data_b), 32'(e.data));
      check({tag, ".alt_led"},   32'(dut_alt.led), 32'(e.led));
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{1'b1, '{1'b0, 8'h00, 8'h00, 3'd0, 16'h0000}};
      vecs[1] = '{1'b0, '{1'b1, 8'h00, 8'hAA, 3'd1, 16'h0000}};
      vecs[2] = '{1'b0, '{1'b1, 8'h01, 8'h55, 3'd2, 16'h00AA}};
      vecs[3] = '{1'b0, '{1'b1, 8'h00, 8'h0F, 3'd3, 16'h55AA}};
      vecs[4] = '{1'b0, '{1'b1, 8'h01, 8'hF0, 3'd4, 16'h550F}};
      vecs[5] = '{1'b0, '{1'b0, 8'h00, 8'h00, 3'd4, 16'hF00F}};
      vecs[6] = '{1'b0, '{1'b0, 8'h00, 8'h00, 3'd4, 16'hF00F}};

      // Directed boot sequence from a fixed table.
      for (int i = 0; i < 7; i++) begin
         step(vecs[i].rst);
         check_main($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Long idle: nothing moves after the program ends.
      for (int i = 0; i < 30; i++) begin
         step(1'b0);
         check_main("idle", '{1'b0, 8'h00, 8'h00, 3'd4, 16'hF00F});
      end

      // Reset mid-program, after E2, clears the partial LED image.
      step(1'b1);
      step(1'b0);
      step(1'b0);
      step(1'b0);
      check("mid.led_before", 32'(dut.led), 32'h55AA);
      step(1'b1);
      check_main("mid.reset", '{1'b0, 8'h00, 8'h00, 3'd0, 16'h0000});
      step(1'b0);
      check_main("mid.replay_e0", '{1'b1, 8'h00, 8'hAA, 3'd1, 16'h0000});
      for (int i = 0; i < 4; i++) step(1'b0);
      check_main("mid.final", '{1'b0, 8'h00, 8'h00, 3'd4, 16'hF00F});

      // Alternate ROM: the write to 8'h07 must leave the LED image unchanged.
      step(1'b1);
      step(1'b0);
      step(1'b0);
      check("alt.led_e1", 32'(dut_alt.led), 32'h00AA);
      check("alt.bus_e1", 32'({data_address_b, write_data_b}), 32'h0755);
      step(1'b0);
      check("alt.led_e2", 32'(dut_alt.led), 32'h00AA);
      step(1'b0);
      step(1'b0);
      check("alt.led_e4", 32'(dut_alt.led), 32'hF00F);

      // Random resets checked against the model for both ROM images.
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 11) == 0);
         check_main("rand", model(ROM_DEFAULT, cnt));
         check_alt("rand", model(ROM_ALT, cnt));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
